mem_seq_ctrl: RTL and testbench
===============================

# mem_seq_ctrl

Parametrised memory sequencing controller for the image/accumulator RAM. It sequences an automatic clear sweep after reset or on request, then calculation-phase writes and shift counting, then display-phase read-out. It extends the single-bank clear/calc/display sequencer with configurable depth, widths, counter wrap, multiple RAM banks with round-robin bank rotation, display wrap detection, address-overflow flagging and a mid-operation clear request. It sits between the datapath/UI control strobes and the RAM address/write-enable pins.

## Interface
- ADDR_W, 11: RAM address width.
- CLR_DEPTH, 393: words cleared per bank (addresses 0..CLR_DEPTH-1); 2 ≤ CLR_DEPTH ≤ 2**ADDR_W.
- DISP_DEPTH, 393: words read per display pass; 2 ≤ DISP_DEPTH ≤ 2**ADDR_W.
- CNT_W, 5: shift counter width.
- CNT_WRAP, 28: counter value at which the next shift reloads.
- CNT_RELOAD, 1: value loaded on wrap.
- NBANKS, 2: number of RAM banks, ≥1; BANK_W = max(1, $clog2(NBANKS)).

Ports:
- CLK  in  1  clock, rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- clr_req  in  1  restart the clear sweep from any state.
- wr_n  in  1  active-low calc write strobe.
- shift  in  1  advance the shift counter (CALC).
- display  in  1  enter DISPLAY (CALC).
- addr_increment  in  1  step the read address (DISPLAY).
- clc  in  1  leave DISPLAY, return to CALC.
- WRITEn  out  1  active-low RAM write enable.
- ADDR  out  ADDR_W  RAM address.
- BANK  out  BANK_W  selected RAM bank.
- counter  out  CNT_W  shift counter.
- busy  out  1  high while in CLEAR.
- disp_wrap  out  1  one-cycle pulse on display address wrap.
- addr_ovf  out  1  sticky flag: a calc write wrapped the address.

## Operation
- States: CLEAR, CALC, DISPLAY. State, ADDR, BANK, counter and addr_ovf are registered. WRITEn, busy and disp_wrap are decoded combinationally from the current state and inputs.
- Reset values: state CLEAR, ADDR 0, BANK 0, counter 0, addr_ovf 0. Consequently WRITEn=0, busy=1 and disp_wrap=0 while reset is held.
- **clr_req** has the highest priority in every state. The next state is CLEAR, ADDR 0, BANK 0, counter 0, addr_ovf 0. WRITEn in that cycle follows the current state.
- **CLEAR**
  - WRITEn=0 every cycle; ADDR increments.
  - At ADDR==CLR_DEPTH-1: ADDR→0 and BANK increments.
  - At the last word of the last bank: next state CALC, ADDR 0, BANK 0.
  - The sweep takes exactly NBANKS*CLR_DEPTH cycles.
- **CALC**: priority is ~wr_n > shift > display.
  - WRITEn = wr_n.
  - ~wr_n: ADDR+1. At ADDR==2**ADDR_W-1 the address wraps to 0 and addr_ovf is set.
  - shift: counter+1, or counter→CNT_RELOAD when counter==CNT_WRAP.
  - display: next state DISPLAY, ADDR 0, counter 0.
- **DISPLAY**: priority is addr_increment > clc. WRITEn=1.
  - addr_increment: ADDR+1.
  - At ADDR==DISP_DEPTH-1, addr_increment sends ADDR→0, asserts disp_wrap in that cycle, and keeps the state in DISPLAY.
  - clc: next state CALC, ADDR 0, BANK←(BANK+1) mod NBANKS, addr_ovf cleared.
- Inputs not listed for a state are ignored in that state.
- Arithmetic: all increments are modulo 2**width. counter is never compared beyond CNT_WRAP; if counter>CNT_WRAP it keeps incrementing naturally.

## Timing
- Register updates occur on the CLK edge after the qualifying input; ADDR/BANK/counter change 1 cycle after the strobe.
- WRITEn in CALC has zero latency from wr_n, so the RAM captures the current ADDR and the address advances afterwards.
- First CALC cycle after reset release: cycle NBANKS*CLR_DEPTH.
- Simultaneous wr_n=0 and display: the write wins and display is lost. The requester holds display until a cycle with wr_n=1.
- Reset asserted mid-sweep or mid-display: all registers return to reset values immediately (asynchronous). Release is synchronised externally.

## Structure
- Package mem_seq_pkg holds:
  - typedef enum logic [1:0] {ST_CLEAR, ST_CALC, ST_DISPLAY} seq_state_t;
  - default parameter constants;
  - the bank-width helper function.
- One sub-module, wrap_counter (parametrised width, wrap value, reload value, enable, synchronous clear), used for the shift counter.
- Address/bank logic stays in the top level.

## Test plan
- **Reset, defaults.** Release reset → WRITEn=0 for 786 cycles; ADDR runs 0..392 with BANK 0, then 0..392 with BANK 1; cycle 786 in CALC with ADDR=0, BANK=0, busy=0.
- **Calc writes and counter wrap.** In CALC, 5 cycles of wr_n=0 → WRITEn low on each, ADDR=5. Then 30 shift pulses → counter 1..28, then 1, 2.
- **Priority.** wr_n=0 with display=1 → ADDR+1, state remains CALC. Next cycle display alone → DISPLAY, ADDR=0, counter=0.
- **Display wrap and bank rotation.** 393 addr_increment pulses → disp_wrap pulses once at ADDR 392→0. clc → CALC, BANK=1; a second pass + clc → BANK=0.
- **Overflow, mid-op clear, reset.**
  - ADDR_W=4, 17 writes → addr_ovf=1, ADDR=1.
  - clr_req in DISPLAY → busy=1 next cycle, ADDR=0, addr_ovf=0.
  - RESETn low mid-sweep → ADDR=0 asynchronously.

Source files
------------

// File: rtl/mem_seq_ctrl_pkg.sv
// Shared types, default parameters and helpers for the memory sequencing controller.
package mem_seq_pkg;

    typedef enum logic [1:0] {ST_CLEAR, ST_CALC, ST_DISPLAY} seq_state_t;

    localparam int DEF_ADDR_W     = 11;
    localparam int DEF_CLR_DEPTH  = 393;
    localparam int DEF_DISP_DEPTH = 393;
    localparam int DEF_CNT_W      = 5;
    localparam int DEF_CNT_WRAP   = 28;
    localparam int DEF_CNT_RELOAD = 1;
    localparam int DEF_NBANKS     = 2;

    // Bank select width: at least one bit, even for a single bank.
    function automatic int bank_width(input int nbanks);
        if (nbanks <= 2) begin
            return 1;
        end
        return $clog2(nbanks);
    endfunction

endpackage

// File: rtl/mem_seq_ctrl_wrap_counter.sv
// Shift counter with configurable wrap/reload value and a synchronous clear.
// Clear takes priority over enable; above WRAP the count simply keeps rolling.
module wrap_counter
    import mem_seq_pkg::*;
#(
    parameter int W      = DEF_CNT_W,
    parameter int WRAP   = DEF_CNT_WRAP,
    parameter int RELOAD = DEF_CNT_RELOAD
) (
    input  logic         CLK,
    input  logic         RESETn,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, reload on wrap, or plain modulo-2**W increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == W'(WRAP)) begin
                cnt_d = W'(RELOAD);
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    // Count register, asynchronously cleared.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_seq_ctrl.sv
// Memory sequencing controller: clear sweep over all banks, calc-phase writes
// with shift counting, display-phase read-out with bank rotation on exit.
//
// Strobe semantics: every control input is a level sampled on each rising CLK
// edge; there is no ready/ack. A strobe that loses arbitration in a cycle is
// dropped, so the requester keeps it asserted until the cycle it takes effect.
module mem_seq_ctrl
    import mem_seq_pkg::*;
#(
    parameter  int ADDR_W     = DEF_ADDR_W,
    parameter  int CLR_DEPTH  = DEF_CLR_DEPTH,
    parameter  int DISP_DEPTH = DEF_DISP_DEPTH,
    parameter  int CNT_W      = DEF_CNT_W,
    parameter  int CNT_WRAP   = DEF_CNT_WRAP,
    parameter  int CNT_RELOAD = DEF_CNT_RELOAD,
    parameter  int NBANKS     = DEF_NBANKS,
    localparam int BANK_W     = bank_width(NBANKS)
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              clr_req,
    input  logic              wr_n,
    input  logic              shift,
    input  logic              display,
    input  logic              addr_increment,
    input  logic              clc,
    output logic              WRITEn,
    output logic [ADDR_W-1:0] ADDR,
    output logic [BANK_W-1:0] BANK,
    output logic [CNT_W-1:0]  counter,
    output logic              busy,
    output logic              disp_wrap,
    output logic              addr_ovf,
    output seq_state_t        state_dbg_o
);

    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(CLR_DEPTH - 1);
    localparam logic [ADDR_W-1:0] DISP_LAST = ADDR_W'(DISP_DEPTH - 1);
    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NBANKS - 1);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              ovf_q, ovf_d;
    logic              cnt_en, cnt_clr;
    logic              bank_last;

    assign bank_last = (bank_q == BANK_LAST);

    // Next-state, address/bank/overflow updates and decoded outputs.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        bank_d    = bank_q;
        ovf_d     = ovf_q;
        WRITEn    = 1'b1;
        busy      = 1'b0;
        disp_wrap = 1'b0;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                WRITEn = 1'b0;
                busy   = 1'b1;
                if (addr_q == CLR_LAST) begin
                    addr_d = '0;
                    if (bank_last) begin
                        bank_d  = '0;
                        state_d = ST_CALC;
                    end else begin
                        bank_d = bank_q + BANK_W'(1);
                    end
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end

            ST_CALC: begin
                // Write strobe drives the RAM directly; address advances after.
                WRITEn = wr_n;
                if (!wr_n) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (addr_q == '1) begin
                        ovf_d = 1'b1;
                    end
                end else if (shift) begin
                    cnt_en = 1'b1;
                end else if (display) begin
                    state_d = ST_DISPLAY;
                    addr_d  = '0;
                    cnt_clr = 1'b1;
                end
            end

            ST_DISPLAY: begin
                if (addr_increment) begin
                    if (addr_q == DISP_LAST) begin
                        addr_d    = '0;
                        disp_wrap = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end else if (clc) begin
                    state_d = ST_CALC;
                    addr_d  = '0;
                    bank_d  = bank_last ? '0 : bank_q + BANK_W'(1);
                    ovf_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        // A clear request overrides whatever the state wanted to do,
        // but WRITEn for this cycle still reflects the current state.
        if (clr_req) begin
            state_d   = ST_CLEAR;
            addr_d    = '0;
            bank_d    = '0;
            ovf_d     = 1'b0;
            cnt_en    = 1'b0;
            cnt_clr   = 1'b1;
            disp_wrap = 1'b0;
        end
    end

    // State, address, bank and overflow registers.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= ST_CLEAR;
            addr_q  <= '0;
            bank_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bank_q  <= bank_d;
            ovf_q   <= ovf_d;
        end
    end

    wrap_counter #(
        .W      (CNT_W),
        .WRAP   (CNT_WRAP),
        .RELOAD (CNT_RELOAD)
    ) u_shift_cnt (
        .CLK    (CLK),
        .RESETn (RESETn),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .cnt_o  (counter)
    );

    assign ADDR        = addr_q;
    assign BANK        = bank_q;
    assign addr_ovf    = ovf_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl: default-parameter instance checked every
// cycle against a reference model, plus a 4-bit-address instance for overflow.
module tb_mem_seq_ctrl;
    import mem_seq_pkg::*;

    localparam int ADDR_W     = 11;
    localparam int CLR_DEPTH  = 393;
    localparam int DISP_DEPTH = 393;
    localparam int CNT_W      = 5;
    localparam int CNT_WRAP   = 28;
    localparam int CNT_RELOAD = 1;
    localparam int NBANKS     = 2;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic              RESETn;
    logic              clr_req, wr_n, shift, display, addr_increment, clc;
    logic              WRITEn, busy, disp_wrap, addr_ovf;
    logic [10:0]       ADDR;
    logic [0:0]        BANK;
    logic [4:0]        counter;
    seq_state_t        dut_state;

    logic              s_rstn, s_clr_req, s_wr_n, s_shift, s_display, s_addr_inc, s_clc;
    logic              s_writen, s_busy, s_disp_wrap, s_ovf;
    logic [3:0]        s_addr;
    logic [0:0]        s_bank;
    logic [4:0]        s_counter;
    seq_state_t        s_state;

    mem_seq_ctrl dut (
        .CLK            (CLK),
        .RESETn         (RESETn),
        .clr_req        (clr_req),
        .wr_n           (wr_n),
        .shift          (shift),
        .display        (display),
        .addr_increment (addr_increment),
        .clc            (clc),
        .WRITEn         (WRITEn),
        .ADDR           (ADDR),
        .BANK           (BANK),
        .counter        (counter),
        .busy           (busy),
        .disp_wrap      (disp_wrap),
        .addr_ovf       (addr_ovf),
        .state_dbg_o    (dut_state)
    );

    mem_seq_ctrl #(
        .ADDR_W     (4),
        .CLR_DEPTH  (16),
        .DISP_DEPTH (16),
        .NBANKS     (2)
    ) dut_small (
        .CLK            (CLK),
        .RESETn         (s_rstn),
        .clr_req        (s_clr_req),
        .wr_n           (s_wr_n),
        .shift          (s_shift),
        .display        (s_display),
        .addr_increment (s_addr_inc),
        .clc            (s_clc),
        .WRITEn         (s_writen),
        .ADDR           (s_addr),
        .BANK           (s_bank),
        .counter        (s_counter),
        .busy           (s_busy),
        .disp_wrap      (s_disp_wrap),
        .addr_ovf       (s_ovf),
        .state_dbg_o    (s_state)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [22:0] exp_q[$];
    logic [4:0]  cnt_exp_q[$];
    logic        last_dw;

    int m_state, m_addr, m_bank, m_cnt, m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_addr = 0; m_bank = 0; m_cnt = 0; m_ovf = 0;
    endtask

    // Expected {state, WRITEn, busy, disp_wrap, addr_ovf, BANK, ADDR, counter}.
    function automatic logic [22:0] model_vec();
        logic we, bsy, dw;
        logic [1:0]  st;
        logic [10:0] a;
        logic [4:0]  c;
        we  = (m_state == 0) ? 1'b0 : (m_state == 1) ? wr_n : 1'b1;
        bsy = (m_state == 0);
        dw  = (m_state == 2) && addr_increment && !clr_req && (m_addr == DISP_DEPTH - 1);
        st  = 2'(m_state);
        a   = 11'(m_addr);
        c   = 5'(m_cnt);
        return {st, we, bsy, dw, (m_ovf != 0), (m_bank != 0), a, c};
    endfunction

    function automatic logic [22:0] obs_vec();
        return {2'(dut_state), WRITEn, busy, disp_wrap, addr_ovf, BANK, ADDR, counter};
    endfunction

    task automatic model_next();
        if (clr_req) begin
            model_reset();
        end else begin
            case (m_state)
                0: begin
                    if (m_addr == CLR_DEPTH - 1) begin
                        m_addr = 0;
                        if (m_bank == NBANKS - 1) begin
                            m_bank = 0; m_state = 1;
                        end else begin
                            m_bank++;
                        end
                    end else begin
                        m_addr++;
                    end
                end
                1: begin
                    if (!wr_n) begin
                        if (m_addr == (1 << ADDR_W) - 1) begin m_addr = 0; m_ovf = 1; end
                        else m_addr++;
                    end else if (shift) begin
                        m_cnt = (m_cnt == CNT_WRAP) ? CNT_RELOAD : (m_cnt + 1) % (1 << CNT_W);
                    end else if (display) begin
                        m_state = 2; m_addr = 0; m_cnt = 0;
                    end
                end
                default: begin
                    if (addr_increment) begin
                        m_addr = (m_addr + 1) % DISP_DEPTH;
                    end else if (clc) begin
                        m_state = 1; m_addr = 0; m_bank = (m_bank + 1) % NBANKS; m_ovf = 0;
                    end
                end
            endcase
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge with inputs set; checks mid-cycle, then advances one cycle.
    task automatic step(input string tag);
        logic [22:0] got, expv;
        exp_q.push_back(model_vec());
        @(negedge CLK);
        got     = obs_vec();
        expv    = exp_q.pop_front();
        last_dw = got[18];
        check(tag, 32'(got), 32'(expv));
        model_next();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int wraps, wrap_at, cyc;

        RESETn = 1'b0; clr_req = 1'b0; wr_n = 1'b1; shift = 1'b0;
        display = 1'b0; addr_increment = 1'b0; clc = 1'b0;
        s_rstn = 1'b0; s_clr_req = 1'b0; s_wr_n = 1'b1; s_shift = 1'b0;
        s_display = 1'b0; s_addr_inc = 1'b0; s_clc = 1'b0;
        model_reset();

        // Reset held: decoded outputs and registers at reset values.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_writen", 32'(WRITEn), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_disp_wrap", 32'(disp_wrap), 32'd0);
        check("rst_addr", 32'(ADDR), 32'd0);
        check("rst_ovf", 32'(addr_ovf), 32'd0);
        @(posedge CLK);
        #1;
        RESETn = 1'b1;

        // Clear sweep over both banks.
        for (int i = 0; i < NBANKS * CLR_DEPTH; i++) step("clear_sweep");
        check("sweep_end_state", 32'(dut_state), 32'(ST_CALC));
        check("sweep_end_busy", 32'(busy), 32'd0);
        check("sweep_end_addr", 32'(ADDR), 32'd0);
        check("sweep_end_bank", 32'(BANK), 32'd0);

        // Calc writes.
        wr_n = 1'b0;
        for (int i = 0; i < 5; i++) step("calc_write");
        wr_n = 1'b1;
        check("calc_addr5", 32'(ADDR), 32'd5);

        // Shift counter wrap: 1..28, then reload 1, then 2.
        for (int v = 1; v <= 28; v++) cnt_exp_q.push_back(5'(v));
        cnt_exp_q.push_back(5'd1);
        cnt_exp_q.push_back(5'd2);
        shift = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step("shift");
            check("shift_cnt", 32'(counter), 32'(cnt_exp_q.pop_front()));
        end
        shift = 1'b0;

        // Write beats display in the same cycle.
        wr_n = 1'b0; display = 1'b1;
        step("prio_wr_disp");
        check("prio_addr", 32'(ADDR), 32'd6);
        check("prio_state", 32'(dut_state), 32'(ST_CALC));
        wr_n = 1'b1;
        step("prio_disp");
        display = 1'b0;
        check("disp_state", 32'(dut_state), 32'(ST_DISPLAY));
        check("disp_addr", 32'(ADDR), 32'd0);
        check("disp_cnt", 32'(counter), 32'd0);

        // Two display passes with bank rotation on each exit.
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                display = 1'b1;
                step("reenter_disp");
                display = 1'b0;
            end
            wraps = 0; wrap_at = -1;
            addr_increment = 1'b1;
            for (int i = 0; i < DISP_DEPTH; i++) begin
                step("disp_inc");
                if (last_dw) begin wraps++; wrap_at = i; end
            end
            addr_increment = 1'b0;
            check("disp_wrap_count", 32'(wraps), 32'd1);
            check("disp_wrap_at", 32'(wrap_at), 32'(DISP_DEPTH - 1));
            check("disp_wrap_addr", 32'(ADDR), 32'd0);
            clc = 1'b1;
            step("clc");
            clc = 1'b0;
            check("clc_state", 32'(dut_state), 32'(ST_CALC));
            check("clc_bank", 32'(BANK), (pass == 0) ? 32'd1 : 32'd0);
        end

        // Clear request from DISPLAY.
        display = 1'b1;
        step("disp_for_clr");
        display = 1'b0;
        addr_increment = 1'b1;
        for (int i = 0; i < 3; i++) step("disp_inc_pre_clr");
        addr_increment = 1'b0;
        clr_req = 1'b1;
        step("clr_in_disp");
        clr_req = 1'b0;
        check("clr_busy", 32'(busy), 32'd1);
        check("clr_addr", 32'(ADDR), 32'd0);
        check("clr_ovf", 32'(addr_ovf), 32'd0);
        for (int i = 0; i < 100; i++) step("clr_sweep");

        // Asynchronous reset mid-sweep, between clock edges.
        #2;
        RESETn = 1'b0;
        #1;
        check("async_rst_addr", 32'(ADDR), 32'd0);
        check("async_rst_state", 32'(dut_state), 32'(ST_CLEAR));
        model_reset();
        @(posedge CLK);
        #1;
        RESETn = 1'b1;
        for (int i = 0; i < 5; i++) step("post_rst_sweep");

        // Small instance: sweep length, then address overflow.
        s_rstn = 1'b1;
        cyc = 0;
        @(negedge CLK);
        while (s_busy === 1'b1 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        check("small_sweep_len", 32'(cyc), 32'd32);
        s_wr_n = 1'b0;
        repeat (15) @(posedge CLK);
        @(negedge CLK);
        check("small_addr15", 32'(s_addr), 32'd15);
        check("small_ovf_pre", 32'(s_ovf), 32'd0);
        check("small_writen", 32'(s_writen), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        s_wr_n = 1'b1;
        @(negedge CLK);
        check("small_ovf", 32'(s_ovf), 32'd1);
        check("small_addr1", 32'(s_addr), 32'd1);
        s_display = 1'b1;
        @(posedge CLK);
        #1;
        s_display = 1'b0;
        @(negedge CLK);
        check("small_disp_state", 32'(s_state), 32'(ST_DISPLAY));
        check("small_disp_ovf", 32'(s_ovf), 32'd1);
        s_clr_req = 1'b1;
        #1;
        check("small_clr_writen", 32'(s_writen), 32'd1);
        @(posedge CLK);
        #1;
        s_clr_req = 1'b0;
        @(negedge CLK);
        check("small_clr_busy", 32'(s_busy), 32'd1);
        check("small_clr_addr", 32'(s_addr), 32'd0);
        check("small_clr_ovf", 32'(s_ovf), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
